// File: rtl/ani_pkg.sv
// Shared widths, FSM state type and shuffle LFSR constants
// for the animation frame sequencer.
package ani_pkg;

  localparam int ANI_W      = 6;
  localparam int FRAME_W    = 5;
  localparam int LIMIT_W    = 6;
  localparam int MAX_FRAMES = 32;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    RUN,
    PAUSED,
    SWITCH
  } state_t;

  function automatic logic [LIMIT_W-1:0] lim_clamp(
    input logic [LIMIT_W-1:0] l
  );
    if (l == '0)
      return LIMIT_W'(1);
    if (l > LIMIT_W'(MAX_FRAMES))
      return LIMIT_W'(MAX_FRAMES);
    return l;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame prescaler: one tick every max(1, BASE_DIV >> speed)
// cycles, freezable with hold and zeroed with clear.
module frame_tick_gen #(
  parameter int BASE_DIV = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] speed,
  input  logic       hold,
  input  logic       clear,
  output logic       tick
);

  localparam int CNT_W =
    (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;

  logic [31:0]      shifted;
  logic [CNT_W-1:0] last;
  logic [CNT_W-1:0] count;

  assign shifted = 32'(BASE_DIV) >> speed;
  assign last    = (shifted == 32'd0) ? '0
                 : CNT_W'(shifted - 32'd1);

  // >= so a speed-up past the current count fires at once
  assign tick = !hold && !clear && (count >= last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clear || tick)
      count <= '0;
    else if (!hold)
      count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/frame_sequencer.sv
// Animation/frame sequencer; define SHUFFLE_ORDER_EN for
// LFSR-shuffled auto/next animation order.
import ani_pkg::*;

module frame_sequencer #(
  parameter int BASE_DIV = 1_000_000,
  parameter int LOOPS    = 2,
  parameter int NUM_ANI  = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LIMIT_W-1:0] limit_i,
  input  logic [2:0]         speed_i,
  input  logic               pause_i,
  input  logic               auto_i,
  input  logic               next_i,
  input  logic               load_i,
  input  logic [ANI_W-1:0]   sel_i,
  output logic [ANI_W-1:0]   animation_o,
  output logic [FRAME_W-1:0] frame_o,
  output logic               frame_stb_o,
  output logic               ani_done_o
);

  localparam int LOOP_W = $clog2(LOOPS + 1);
  localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(LOOPS - 1);
  localparam logic [LOOP_W-1:0] LOOP_MAX  = LOOP_W'(LOOPS);

  state_t             state;
  logic [LOOP_W-1:0]  loops;
  logic               fresh;
  logic               sw_load;
  logic [ANI_W-1:0]   sw_sel;
  logic               tick_raw;
  logic               tick;
  logic               wrap;
  logic [LIMIT_W-1:0] lim_eff;
  logic [ANI_W-1:0]   seq_next;
  logic [ANI_W-1:0]   adv_next;

  frame_tick_gen #(
    .BASE_DIV(BASE_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .speed(speed_i),
    .hold (pause_i),
    .clear(state == SWITCH),
    .tick (tick_raw)
  );

  // limit_i is stale right after a switch; skip that cycle
  assign tick     = tick_raw && !fresh;
  assign lim_eff  = lim_clamp(limit_i);
  assign wrap     = {1'b0, frame_o} >= (lim_eff - LIMIT_W'(1));
  assign seq_next = ANI_W'((32'(animation_o) + 32'd1) % NUM_ANI);

`ifdef SHUFFLE_ORDER_EN
  logic [15:0]      lfsr;
  logic [ANI_W-1:0] pick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lfsr <= LFSR_SEED;
    else
      lfsr <= {1'b0, lfsr[15:1]}
            ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  end

  assign pick     = ANI_W'(32'(lfsr[5:0]) % NUM_ANI);
  assign adv_next = (pick == animation_o) ? seq_next : pick;
`else
  assign adv_next = seq_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      animation_o <= '0;
      frame_o     <= '0;
      frame_stb_o <= 1'b0;
      ani_done_o  <= 1'b0;
      loops       <= '0;
      fresh       <= 1'b0;
      sw_load     <= 1'b0;
      sw_sel      <= '0;
    end else begin
      frame_stb_o <= 1'b0;
      ani_done_o  <= 1'b0;
      fresh       <= 1'b0;
      unique case (state)
        RUN, PAUSED: begin
          state <= pause_i ? PAUSED : RUN;
          if (load_i) begin
            state   <= SWITCH;
            sw_load <= 1'b1;
            sw_sel  <= sel_i;
          end else if (next_i) begin
            state   <= SWITCH;
            sw_load <= 1'b0;
          end else if (tick) begin
            frame_stb_o <= 1'b1;
            if (!wrap) begin
              frame_o <= frame_o + FRAME_W'(1);
            end else begin
              frame_o <= '0;
              if (loops != LOOP_MAX)
                loops <= loops + LOOP_W'(1);
              if (auto_i && loops >= LOOP_LAST) begin
                state   <= SWITCH;
                sw_load <= 1'b0;
              end
            end
          end
        end
        SWITCH: begin
          animation_o <= sw_load
                       ? ANI_W'(32'(sw_sel) % NUM_ANI)
                       : adv_next;
          frame_o     <= '0;
          loops       <= '0;
          frame_stb_o <= 1'b1;
          ani_done_o  <= 1'b1;
          fresh       <= 1'b1;
          state       <= pause_i ? PAUSED : RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
